// File: rtl/board_reset_sequencer.sv
// Board reset controller: button debounce, PLL reset pulse, lock supervision with retry, staged channel release.
// Optional lock-loss counter port is built when RSTSEQ_LOSS_COUNT_EN is defined.
module board_reset_sequencer #(
   parameter int CHANNELS           = 2,
   parameter int DEBOUNCE_CYCLES    = 240000,
   parameter int PLL_RST_CYCLES     = 24,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP          = 16,
   parameter int LOCK_TIMEOUT       = 2400000,
   parameter int BTN_ACTIVE_LOW     = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                btn_in,
   input  logic                pll_locked,
   output logic                pll_rst,
   output logic [CHANNELS-1:0] chan_reset,
   output logic                all_released,
   output logic [2:0]          state_dbg
`ifdef RSTSEQ_LOSS_COUNT_EN
   ,
   output logic [7:0]          lock_loss_count
`endif
);

   localparam int REL_LAST_I = (CHANNELS - 1) * STAGE_GAP;
   localparam int MAX_A      = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_B      = (LOCK_TIMEOUT > REL_LAST_I + 1) ? LOCK_TIMEOUT : REL_LAST_I + 1;
   localparam int CNT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic BTN_LOW  = (BTN_ACTIVE_LOW != 0);

   localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_LAST_I);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_PLLRST   = 3'd0,
      S_WAITLOCK = 3'd1,
      S_STABLE   = 3'd2,
      S_RELEASE  = 3'd3,
      S_RUN      = 3'd4
   } state_t;

   logic [1:0]          r_btn_sync;
   logic [1:0]          r_lock_sync;
   logic                r_btn_db;
   logic [DB_W-1:0]     r_db_cnt;
   logic                r_press;
   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_pll_rst;
   logic [CHANNELS-1:0] r_chan_reset;
   logic                r_all_released;

   logic                w_btn_sample;
   logic                w_lock;
   state_t              w_state_nx;
   logic [CNT_W-1:0]    w_cnt_nx;
   logic                w_pll_rst_nx;
   logic [CHANNELS-1:0] w_chan_nx;
   logic                w_all_nx;

   // r_btn_db holds the accepted level as "pressed" (1) regardless of button polarity.
   assign w_btn_sample = r_btn_sync[1] ^ BTN_LOW;
   assign w_lock       = r_lock_sync[1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_btn_sync  <= {2{BTN_LOW}};
         r_lock_sync <= 2'b00;
         r_btn_db    <= 1'b0;
         r_db_cnt    <= '0;
         r_press     <= 1'b0;
      end else begin
         r_btn_sync  <= {r_btn_sync[0], btn_in};
         r_lock_sync <= {r_lock_sync[0], pll_locked};
         r_press     <= 1'b0;
         if (w_btn_sample == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= w_btn_sample;
            r_db_cnt <= '0;
            r_press  <= w_btn_sample;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= S_PLLRST;
         r_cnt          <= '0;
         r_pll_rst      <= 1'b1;
         r_chan_reset   <= '1;
         r_all_released <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_cnt          <= w_cnt_nx;
         r_pll_rst      <= w_pll_rst_nx;
         r_chan_reset   <= w_chan_nx;
         r_all_released <= w_all_nx;
      end
   end

   // Outputs are computed for the next state so they change on the same edge as the state.
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_pll_rst_nx = r_pll_rst;
      w_chan_nx    = r_chan_reset;
      w_all_nx     = r_all_released;
      if (r_press) begin
         w_state_nx   = S_PLLRST;
         w_cnt_nx     = '0;
         w_pll_rst_nx = 1'b1;
         w_chan_nx    = '1;
         w_all_nx     = 1'b0;
      end else begin
         case (r_state)
            S_PLLRST: begin
               if (r_cnt == PLL_LAST) begin
                  w_state_nx   = S_WAITLOCK;
                  w_cnt_nx     = '0;
                  w_pll_rst_nx = 1'b0;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            S_WAITLOCK: begin
               if (w_lock) begin
                  w_state_nx = S_STABLE;
                  w_cnt_nx   = '0;
               end else if (r_cnt == TO_LAST) begin
                  w_state_nx   = S_PLLRST;
                  w_cnt_nx     = '0;
                  w_pll_rst_nx = 1'b1;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            S_STABLE: begin
               if (!w_lock) begin
                  w_state_nx = S_WAITLOCK;
                  w_cnt_nx   = '0;
               end else if (r_cnt == STB_LAST) begin
                  w_state_nx   = S_RELEASE;
                  w_cnt_nx     = '0;
                  w_chan_nx[0] = 1'b0;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (!w_lock) begin
                  w_state_nx = S_WAITLOCK;
                  w_cnt_nx   = '0;
                  w_chan_nx  = '1;
               end else if (r_cnt == REL_LAST) begin
                  w_state_nx = S_RUN;
                  w_cnt_nx   = '0;
                  w_all_nx   = 1'b1;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
                  for (int i = 1; i < CHANNELS; i++) begin
                     if (r_cnt == CNT_W'(i * STAGE_GAP - 1)) w_chan_nx[i] = 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (!w_lock) begin
                  w_state_nx = S_WAITLOCK;
                  w_cnt_nx   = '0;
                  w_chan_nx  = '1;
                  w_all_nx   = 1'b0;
               end
            end
            default: begin
               w_state_nx   = S_PLLRST;
               w_cnt_nx     = '0;
               w_pll_rst_nx = 1'b1;
               w_chan_nx    = '1;
               w_all_nx     = 1'b0;
            end
         endcase
      end
   end

   assign pll_rst      = r_pll_rst;
   assign chan_reset   = r_chan_reset;
   assign all_released = r_all_released;
   assign state_dbg    = r_state;

`ifdef RSTSEQ_LOSS_COUNT_EN
   logic [7:0] r_loss_cnt;
   logic       w_loss;

   // A press wins over lock loss, so that edge is not a lock-loss exit.
   assign w_loss = !r_press && !w_lock &&
                   ((r_state == S_STABLE) || (r_state == S_RELEASE) || (r_state == S_RUN));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_loss_cnt <= 8'd0;
      end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign lock_loss_count = r_loss_cnt;
`endif

endmodule
